// File: rtl/burst_bus_pkg.sv
// Shared types and constants for the burst bus RAM slave: FSM states, bus widths
// and the address-window decode helper.
package burst_bus_pkg;

  localparam int BURST_W  = 8;
  localparam int BE_W     = 4;
  localparam int DATA_W   = 32;
  localparam int WORD_LSB = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_RD_END,
    S_WR,
    S_WR_BUSY,
    S_ERR
  } state_t;

  // Upper address bits above the window must match the window base.
  function automatic logic win_hit(input logic [31:0] addr, input logic [31:0] base, input int aw);
    return (addr >> (aw + WORD_LSB)) == (base >> (aw + WORD_LSB));
  endfunction

endpackage

// File: rtl/burst_ram_slave_if.sv
// Shared-bus signals between the DMA master and the burst RAM slave.
interface burst_ram_slave_if
  import burst_bus_pkg::*;
;
  logic              begin_transaction_in;
  logic [DATA_W-1:0] address_data_in;
  logic [BE_W-1:0]   byte_enables_in;
  logic [BURST_W-1:0] burst_size_in;
  logic              read_n_write_in;
  logic              data_valid_in;
  logic              end_transaction_in;
  logic [DATA_W-1:0] address_data_out;
  logic              data_valid_out;
  logic              end_transaction_out;
  logic              busy_out;
  logic              error_out;

  modport slave (
    input  begin_transaction_in, address_data_in, byte_enables_in, burst_size_in,
           read_n_write_in, data_valid_in, end_transaction_in,
    output address_data_out, data_valid_out, end_transaction_out, busy_out, error_out
  );

  modport master (
    output begin_transaction_in, address_data_in, byte_enables_in, burst_size_in,
           read_n_write_in, data_valid_in, end_transaction_in,
    input  address_data_out, data_valid_out, end_transaction_out, busy_out, error_out
  );
endinterface

// File: rtl/burst_ram_sram.sv
// Single-port synchronous RAM with per-byte write enables; one-cycle read latency,
// read-before-write on the same address, no reset.
module burst_ram_sram
  import burst_bus_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              i_clk,
  input  logic [AW-1:0]     i_addr,
  input  logic [BE_W-1:0]   i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/burst_ram_slave.sv
// Burst RAM bus slave: read words start waitStates edges after begin, one per cycle;
// writes accept one word per cycle and assert busy_out for busyCycles every busyEvery words.
module burst_ram_slave
  import burst_bus_pkg::*;
#(
  parameter logic [31:0] baseAddress = 32'h5000_0000,
  parameter int          addrWidth   = 10,
  parameter int          waitStates  = 2,
  parameter int          busyEvery   = 4,
  parameter int          busyCycles  = 2
) (
  input logic              clock,
  input logic              reset,
  burst_ram_slave_if.slave bus
);
  localparam int             DEPTH_M1 = (1 << addrWidth) - 1;
  localparam logic [3:0]     WS_M1    = 4'(waitStates - 1);
  localparam logic [2:0]     BC_M1    = 3'(busyCycles - 1);
  localparam logic [8:0]     BEV      = 9'(busyEvery);

  state_t               r_state;
  logic [addrWidth-1:0] r_idx;
  logic [BURST_W-1:0]   r_len;
  logic [BURST_W-1:0]   r_cnt;
  logic [BE_W-1:0]      r_be;
  logic [8:0]           r_acc;
  logic [8:0]           r_bev;
  logic [3:0]           r_wcnt;
  logic [2:0]           r_bcnt;
  logic [DATA_W-1:0]    r_dat;
  logic                 r_dv, r_end, r_busy, r_err;

  logic [addrWidth-1:0] w_idx_in;
  logic [31:0]          w_end_idx;
  logic                 w_sel, w_bad, w_acc_try, w_over, w_wr, w_last, w_stall, w_emit;
  logic [8:0]           w_acc_nxt, w_bev_nxt;
  logic [addrWidth-1:0] w_ram_addr;
  logic [BE_W-1:0]      w_ram_be;
  logic [DATA_W-1:0]    w_ram_rdata;

  assign w_idx_in  = bus.address_data_in[addrWidth+1:WORD_LSB];
  assign w_end_idx = 32'(w_idx_in) + 32'(bus.burst_size_in);
  assign w_sel     = bus.begin_transaction_in && (r_state == S_IDLE) &&
                     win_hit(bus.address_data_in, baseAddress, addrWidth);
  assign w_bad     = (bus.address_data_in[1:0] != 2'b00) || (w_end_idx > 32'(DEPTH_M1));

  assign w_acc_try = (r_state == S_WR) && bus.data_valid_in;
  assign w_over    = r_acc > {1'b0, r_len};
  assign w_wr      = w_acc_try && !w_over;
  assign w_acc_nxt = r_acc + 9'd1;
  assign w_bev_nxt = r_bev + 9'd1;
  assign w_last    = w_acc_nxt == ({1'b0, r_len} + 9'd1);
  assign w_stall   = (BEV != 9'd0) && (w_bev_nxt == BEV) && !w_last;

  assign w_emit = ((r_state == S_RD_WAIT) && (r_wcnt == 4'd0)) ||
                  ((r_state == S_RD_BURST) && (r_cnt != '0));

  // The RAM runs one word ahead of the output register so reads stream without gaps.
  always_comb begin
    w_ram_addr = r_idx;
    if (r_state == S_IDLE) w_ram_addr = w_idx_in;
    else if (w_emit)       w_ram_addr = r_idx + addrWidth'(1);
  end

  assign w_ram_be = w_wr ? r_be : '0;

  burst_ram_sram #(.AW(addrWidth)) u_sram (
    .i_clk   (clock),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (bus.address_data_in),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_be    <= '0;
      r_acc   <= '0;
      r_bev   <= '0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
      r_dat   <= '0;
      r_dv    <= 1'b0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_dat <= '0;
      r_dv  <= 1'b0;
      r_end <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_sel) begin
          r_idx  <= w_idx_in;
          r_len  <= bus.burst_size_in;
          r_be   <= bus.byte_enables_in;
          r_acc  <= '0;
          r_bev  <= '0;
          r_wcnt <= WS_M1;
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_state <= bus.read_n_write_in ? S_RD_WAIT : S_WR;
          end
        end
        S_RD_WAIT: if (r_wcnt == 4'd0) begin
          r_dv    <= 1'b1;
          r_dat   <= w_ram_rdata;
          r_idx   <= r_idx + addrWidth'(1);
          r_cnt   <= r_len;
          r_state <= S_RD_BURST;
        end else begin
          r_wcnt <= r_wcnt - 4'd1;
        end
        S_RD_BURST: if (r_cnt != '0) begin
          r_dv  <= 1'b1;
          r_dat <= w_ram_rdata;
          r_idx <= r_idx + addrWidth'(1);
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_end   <= 1'b1;
          r_state <= S_RD_END;
        end
        S_RD_END: r_state <= S_IDLE;
        S_WR: if (w_acc_try && w_over) begin
          r_err   <= 1'b1;
          r_state <= S_ERR;
        end else begin
          if (w_wr) begin
            r_idx <= r_idx + addrWidth'(1);
            r_acc <= w_acc_nxt;
            r_bev <= (w_bev_nxt == BEV) ? 9'd0 : w_bev_nxt;
          end
          if (bus.end_transaction_in) begin
            r_state <= S_IDLE;
          end else if (w_wr && w_stall) begin
            r_busy  <= 1'b1;
            r_bcnt  <= BC_M1;
            r_state <= S_WR_BUSY;
          end
        end
        S_WR_BUSY: if (bus.end_transaction_in || (r_bcnt == 3'd0)) begin
          r_busy  <= 1'b0;
          r_state <= bus.end_transaction_in ? S_IDLE : S_WR;
        end else begin
          r_bcnt <= r_bcnt - 3'd1;
        end
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.address_data_out    = r_dat;
  assign bus.data_valid_out      = r_dv;
  assign bus.end_transaction_out = r_end;
  assign bus.busy_out            = r_busy;
  assign bus.error_out           = r_err;
endmodule
